// File: rtl/svm_feature_feeder.sv
// svm_feature_feeder: buffers the HOG feature stream of one detection window,
// pairs each feature with its weight from a synchronous-read ROM and presents
// each pair to the SVM classifier for a fixed PACE-cycle slot.
module svm_feature_feeder #(
   parameter int N_FEAT     = 3780,
   parameter int AW         = 12,
   parameter int FIFO_DEPTH = 16,
   parameter int PACE       = 20
) (
   input  logic          iClk,
   input  logic          iRst_n,
   input  logic          iWinStart,
   input  logic          iFeat_Valid,
   input  logic [31:0]   iFeat_Data,
   output logic          oFeat_Ready,
   output logic [AW-1:0] oRom_Addr,
   input  logic [31:0]   iRom_Data,
   output logic [31:0]   oHOG_Value,
   output logic [31:0]   oTrained_Value,
   output logic          oReady,
   output logic          oDone,
   output logic          oBusy,
   output logic          oErr
);

   localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, DONE} state_t;

   state_t        r_state;
   state_t        w_state_next;

   logic [31:0]   r_mem [FIFO_DEPTH];
   logic [FW-1:0] r_wr_ptr;
   logic [FW-1:0] r_rd_ptr;
   logic [FW:0]   r_fill;
   logic [31:0]   r_pop_data;
   logic [CW-1:0] r_push_cnt;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_slot;
   logic [AW-1:0] r_rom_addr;
   logic [31:0]   r_hog;
   logic [31:0]   r_trained;
   logic          r_err;

   logic          w_full;
   logic          w_empty;
   logic          w_in_window;
   logic          w_feat_ready;
   logic          w_push;
   logic          w_pop;
   logic          w_start;
   logic          w_slot_end;
   logic          w_last;

   // The push limit keeps a window from swallowing the next window's first words.
   assign w_full       = (r_fill == (FW+1)'(FIFO_DEPTH));
   assign w_empty      = (r_fill == '0);
   assign w_in_window  = (r_state != IDLE) && (r_state != DONE);
   assign w_feat_ready = iRst_n && !w_full && w_in_window && (r_push_cnt < CW'(N_FEAT));
   assign w_push       = iFeat_Valid && w_feat_ready;
   assign w_pop        = iRst_n && (r_state == FETCH) && !w_empty;
   assign w_start      = iWinStart && !w_in_window;
   assign w_slot_end   = (r_state == ISSUE) && (r_slot == PW'(PACE-1));
   assign w_last       = (r_count == CW'(N_FEAT-1));

   assign oFeat_Ready    = w_feat_ready;
   assign oRom_Addr      = r_rom_addr;
   assign oHOG_Value     = r_hog;
   assign oTrained_Value = r_trained;
   assign oReady         = (r_state != ISSUE);
   assign oDone          = (r_state == DONE);
   assign oBusy          = w_in_window;
   assign oErr           = r_err;

   // State register.
   always_ff @(posedge iClk) begin
      if (!iRst_n) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic: one slot per feature, back to FETCH until the last one.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE, DONE: if (iWinStart) w_state_next = FETCH;
         FETCH:      if (!w_empty)  w_state_next = WAIT;
         WAIT:                      w_state_next = ISSUE;
         ISSUE:      if (w_slot_end) w_state_next = w_last ? DONE : FETCH;
         default:                   w_state_next = IDLE;
      endcase
   end

   // FIFO storage with registered read; no reset so it maps onto RAM.
   always_ff @(posedge iClk) begin
      if (w_push) r_mem[r_wr_ptr] <= iFeat_Data;
      if (w_pop)  r_pop_data      <= r_mem[r_rd_ptr];
   end

   // FIFO pointers, fill level and per-window push count.
   always_ff @(posedge iClk) begin
      if (!iRst_n || w_start) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_push_cnt <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr   <= r_wr_ptr + 1'b1;
            r_push_cnt <= r_push_cnt + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_fill <= r_fill + 1'b1;
         else if (!w_push && w_pop) r_fill <= r_fill - 1'b1;
      end
   end

   // Sequencer datapath: ROM address, slot timer, output pair and error flag.
   // The ROM address already equals the count while in FETCH, so the weight is
   // on iRom_Data during WAIT, alongside the popped feature.
   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         r_count    <= '0;
         r_slot     <= '0;
         r_rom_addr <= '0;
         r_hog      <= '0;
         r_trained  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (iWinStart && w_in_window) r_err <= 1'b1;
         if (w_start) begin
            r_count    <= '0;
            r_rom_addr <= '0;
         end
         case (r_state)
            FETCH: if (!w_empty) r_rom_addr <= r_count[AW-1:0];
            WAIT: begin
               r_hog     <= r_pop_data;
               r_trained <= iRom_Data;
               r_slot    <= '0;
            end
            ISSUE: begin
               if (w_slot_end) begin
                  r_slot  <= '0;
                  r_count <= r_count + 1'b1;
                  if (!w_last) r_rom_addr <= r_rom_addr + 1'b1;
               end else begin
                  r_slot <= r_slot + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
